// File: rtl/regfile_write_arbiter_pkg.sv
// Shared widths, load-buffer entry layout and the one-hot helper for the
// register file writeback arbiter.
package regfile_write_arbiter_pkg;

    localparam int ADW  = 5;
    localparam int DW   = 32;
    localparam int NREG = 1 << ADW;

    typedef struct packed {
        logic           live;
        logic [ADW-1:0] addr;
        logic [DW-1:0]  data;
    } ld_entry_t;

    function automatic logic [NREG-1:0] onehot(input logic [ADW-1:0] addr);
        logic [NREG-1:0] v;
        v       = '0;
        v[addr] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus: ALU and load sources in, register file port and hazard mask out.
// The master side is whoever sources the writebacks; the arbiter is the slave.
interface regfile_write_arbiter_if
    import regfile_write_arbiter_pkg::*;
    ;
    logic            alu_we;
    logic [ADW-1:0]  alu_addr;
    logic [DW-1:0]   alu_data;
    logic            ld_valid;
    logic            ld_ready;
    logic [ADW-1:0]  ld_addr;
    logic [DW-1:0]   ld_data;
    logic            wr_en;
    logic [ADW-1:0]  wr_addr;
    logic [DW-1:0]   wr_data;
    logic [NREG-1:0] pending_mask;

    modport master (
        output alu_we, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
        input  ld_ready, wr_en, wr_addr, wr_data, pending_mask
    );

    modport slave (
        input  alu_we, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
        output ld_ready, wr_en, wr_addr, wr_data, pending_mask
    );

endinterface

// File: rtl/regfile_write_arbiter_load_fifo.sv
// Circular load buffer with per-entry live bits; an ALU write squashes every
// buffered entry with the same destination register.
module regwb_load_fifo
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [ADW-1:0]        push_addr,
    input  logic [DW-1:0]         push_data,
    input  logic                  pop,
    input  logic                  squash,
    input  logic [ADW-1:0]        squash_addr,
    output ld_entry_t             head,
    output ld_entry_t [DEPTH-1:0] entries,
    output logic                  full,
    output logic                  empty
);

    localparam int PW = $clog2(DEPTH);

    ld_entry_t [DEPTH-1:0] mem;
    logic [PW-1:0]         rptr, wptr;
    logic [PW:0]           count;
    logic                  do_push, do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rptr];
    assign entries = mem;

    // Later assignments win: a popped slot loses its live bit so live always
    // implies occupied, and a fresh push is live even if squashed this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem   <= '0;
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (squash && mem[i].addr == squash_addr)
                    mem[i].live <= 1'b0;
            end
            if (do_pop) begin
                mem[rptr].live <= 1'b0;
                rptr           <= rptr + 1'b1;
            end
            if (do_push) begin
                mem[wptr] <= '{live: 1'b1, addr: push_addr, data: push_data};
                wptr      <= wptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register file write port owner: ALU results take priority, loads drain from
// a small buffer, and the live buffered destinations are exported as a mask.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    regfile_write_arbiter_if.slave  bus
);

    ld_entry_t             head;
    ld_entry_t [DEPTH-1:0] entries;
    logic                  full, empty;
    logic                  alu_go, head_ok, head_dead, pop;
    logic [NREG-1:0]       mask;

    assign alu_go    = bus.alu_we && (bus.alu_addr != '0);
    assign head_ok   = !empty && head.live && (head.addr != '0);
    // Dead or r0 heads are discarded every cycle, even while the ALU owns the port.
    assign head_dead = !empty && !(head.live && (head.addr != '0));
    assign pop       = head_dead || (head_ok && !alu_go);

    assign bus.ld_ready = !full;

    regwb_load_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (bus.ld_valid),
        .push_addr   (bus.ld_addr),
        .push_data   (bus.ld_data),
        .pop         (pop),
        .squash      (alu_go),
        .squash_addr (bus.alu_addr),
        .head        (head),
        .entries     (entries),
        .full        (full),
        .empty       (empty)
    );

    always_comb begin
        mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries[i].live)
                mask = mask | onehot(entries[i].addr);
        end
    end

    assign bus.pending_mask = mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
        end else begin
            bus.wr_en <= alu_go || head_ok;
            if (alu_go) begin
                bus.wr_addr <= bus.alu_addr;
                bus.wr_data <= bus.alu_data;
            end else if (head_ok) begin
                bus.wr_addr <= head.addr;
                bus.wr_data <= head.data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: vector table plus multi-cycle
// sequences for buffer-full collisions and reset during operation.
module tb_regfile_write_arbiter;
    import regfile_write_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_write_arbiter_if bus();

    regfile_write_arbiter #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        alu_we;
        logic [4:0]  alu_addr;
        logic [31:0] alu_data;
        logic        ld_valid;
        logic [4:0]  ld_addr;
        logic [31:0] ld_data;
        logic        rdy;
        logic        en;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] mask;
    } vec_t;

    vec_t tbl[16];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] aa, input logic [31:0] ad,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld);
        bus.alu_we   = we;
        bus.alu_addr = aa;
        bus.alu_data = ad;
        bus.ld_valid = lv;
        bus.ld_addr  = la;
        bus.ld_data  = ld;
    endtask

    function automatic vec_t mk(input logic we, input logic [4:0] aa, input logic [31:0] ad,
                                input logic lv, input logic [4:0] la, input logic [31:0] ld,
                                input logic rdy, input logic en, input logic [4:0] wa,
                                input logic [31:0] wd, input logic [31:0] mask);
        vec_t v;
        v.alu_we = we; v.alu_addr = aa; v.alu_data = ad;
        v.ld_valid = lv; v.ld_addr = la; v.ld_data = ld;
        v.rdy = rdy; v.en = en; v.wa = wa; v.wd = wd; v.mask = mask;
        return v;
    endfunction

    logic [4:0]  wa_q[$];
    logic [31:0] wd_q[$];
    logic [4:0]  exp_a[$];
    logic [31:0] exp_d[$];

    initial begin
        // Expected values are the outputs just after the edge that consumes the inputs.
        tbl[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,       1, 1, 5, 32'hDEADBEEF, 32'h0);
        tbl[1]  = mk(1, 0, 32'h55,       0, 0, 0,       1, 0, 5, 32'hDEADBEEF, 32'h0);
        tbl[2]  = mk(0, 0, 0,            0, 0, 0,       1, 0, 5, 32'hDEADBEEF, 32'h0);
        tbl[3]  = mk(0, 0, 0,            1, 9, 32'h1234, 1, 0, 5, 32'hDEADBEEF, 32'h200);
        tbl[4]  = mk(0, 0, 0,            0, 0, 0,       1, 1, 9, 32'h1234,     32'h0);
        tbl[5]  = mk(0, 0, 0,            0, 0, 0,       1, 0, 9, 32'h1234,     32'h0);
        tbl[6]  = mk(1, 4, 32'hA,        1, 4, 32'hB,   1, 1, 4, 32'hA,        32'h10);
        tbl[7]  = mk(0, 0, 0,            0, 0, 0,       1, 1, 4, 32'hB,        32'h0);
        tbl[8]  = mk(0, 0, 0,            0, 0, 0,       1, 0, 4, 32'hB,        32'h0);
        tbl[9]  = mk(1, 3, 32'h30,       1, 7, 32'h77,  1, 1, 3, 32'h30,       32'h80);
        tbl[10] = mk(1, 3, 32'h31,       0, 0, 0,       1, 1, 3, 32'h31,       32'h80);
        tbl[11] = mk(1, 7, 32'h70,       0, 0, 0,       1, 1, 7, 32'h70,       32'h0);
        tbl[12] = mk(0, 0, 0,            0, 0, 0,       1, 0, 7, 32'h70,       32'h0);
        tbl[13] = mk(0, 0, 0,            0, 0, 0,       1, 0, 7, 32'h70,       32'h0);
        tbl[14] = mk(0, 0, 0,            1, 0, 32'h99,  1, 0, 7, 32'h70,       32'h1);
        tbl[15] = mk(0, 0, 0,            0, 0, 0,       1, 0, 7, 32'h70,       32'h0);

        // Reset held with random traffic on the inputs
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            drive(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom);
            @(posedge clk); #1;
            chk("rst_wr_en",   {63'd0, bus.wr_en},   64'd0);
            chk("rst_wr_addr", {59'd0, bus.wr_addr}, 64'd0);
            chk("rst_wr_data", {32'd0, bus.wr_data}, 64'd0);
            chk("rst_mask",    {32'd0, bus.pending_mask}, 64'd0);
        end
        drive(0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b1;
        #1 chk("rst_ld_ready", {63'd0, bus.ld_ready}, 64'd1);
        @(posedge clk); #1;

        // Table-driven single-cycle behaviour
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].alu_we, tbl[i].alu_addr, tbl[i].alu_data,
                  tbl[i].ld_valid, tbl[i].ld_addr, tbl[i].ld_data);
            #1 chk($sformatf("v%0d_ld_ready", i), {63'd0, bus.ld_ready}, {63'd0, tbl[i].rdy});
            @(posedge clk); #1;
            chk($sformatf("v%0d_wr_en", i),   {63'd0, bus.wr_en},   {63'd0, tbl[i].en});
            chk($sformatf("v%0d_wr_addr", i), {59'd0, bus.wr_addr}, {59'd0, tbl[i].wa});
            chk($sformatf("v%0d_wr_data", i), {32'd0, bus.wr_data}, {32'd0, tbl[i].wd});
            chk($sformatf("v%0d_mask", i),    {32'd0, bus.pending_mask}, {32'd0, tbl[i].mask});
        end

        // Collision: 6 ALU writes to r3 while 5 loads to r10..r14 compete
        begin
            int   k;
            logic rdy;
            k = 0;
            for (int c = 0; c < 6; c++) begin
                exp_a.push_back(5'd3);
                exp_d.push_back(32'h300 + 32'(c));
            end
            for (int j = 0; j < 5; j++) begin
                exp_a.push_back(5'(10 + j));
                exp_d.push_back(32'h1000 + 32'(10 + j));
            end
            for (int c = 0; c < 20; c++) begin
                drive(c < 6, 5'd3, 32'h300 + 32'(c), k < 5, 5'(10 + k), 32'h1000 + 32'(10 + k));
                #1 rdy = bus.ld_ready;
                if (c == 4) chk("full_ready_c4", {63'd0, rdy}, 64'd0);
                if (c == 5) chk("full_ready_c5", {63'd0, rdy}, 64'd0);
                @(posedge clk); #1;
                if (rdy && k < 5) k++;
                if (bus.wr_en) begin
                    wa_q.push_back(bus.wr_addr);
                    wd_q.push_back(bus.wr_data);
                end
            end
            drive(0, 0, 0, 0, 0, 0);
            chk("coll_accepted", 64'(k), 64'd5);
            chk("coll_nwrites", 64'(wa_q.size()), 64'(exp_a.size()));
            for (int j = 0; j < exp_a.size() && j < wa_q.size(); j++) begin
                chk($sformatf("coll_w%0d_addr", j), {59'd0, wa_q[j]}, {59'd0, exp_a[j]});
                chk($sformatf("coll_w%0d_data", j), {32'd0, wd_q[j]}, {32'd0, exp_d[j]});
            end
            chk("coll_mask_drained", {32'd0, bus.pending_mask}, 64'd0);
        end

        // Reset mid-operation discards buffered loads
        for (int c = 0; c < 3; c++) begin
            drive(1, 5'd3, 32'h3A0 + 32'(c), 1, 5'(20 + c), 32'(c));
            @(posedge clk); #1;
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("mid_mask_before", {32'd0, bus.pending_mask}, 64'h0070_0000);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_en",   {63'd0, bus.wr_en},   64'd0);
        chk("mid_rst_wr_addr", {59'd0, bus.wr_addr}, 64'd0);
        chk("mid_rst_mask",    {32'd0, bus.pending_mask}, 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1 chk("mid_rst_ready", {63'd0, bus.ld_ready}, 64'd1);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk($sformatf("mid_post_wr_en_%0d", c), {63'd0, bus.wr_en}, 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Sole driver of the register file write port (write enable, address, data). Merges two writeback sources: ALU results, which never stall, and load responses from the memory side, which use a valid/ready handshake. A small load buffer absorbs collisions between the two sources. A pending-register mask is exported to hazard logic.

Parameters:
ADW, 5, register address width.
DW, 32, register data width.
DEPTH, 4, load buffer entries; power of two, at least 2.

Ports:
clk  in  1  clock, all state updates on its rising edge.
rst_n  in  1  asynchronous active-low reset.
alu_we  in  1  ALU result valid this cycle; no backpressure.
alu_addr  in  ADW  ALU destination register.
alu_data  in  DW  ALU result.
ld_valid  in  1  load response valid.
ld_ready  out  1  buffer can accept a load response.
ld_addr  in  ADW  load destination register.
ld_data  in  DW  load data.
wr_en  out  1  register file write enable (registered).
wr_addr  out  ADW  register file write address (registered).
wr_data  out  DW  register file write data (registered).
pending_mask  out  2**ADW  bit r is set while a live buffered load targets register r.

Behaviour:
- Reset (async, rst_n=0):
  - wr_en=0, wr_addr=0, wr_data=0.
  - Buffer empty, all entry live bits cleared, pending_mask=0.
  - ld_ready=1 as soon as rst_n deasserts.
- Reset asserted mid-operation discards all buffered loads; they are never written.
- Load acceptance:
  - A load is accepted when ld_valid && ld_ready.
  - ld_ready = !full, computed combinationally from buffer state only; no dependence on the same-cycle pop.
- Write selection, evaluated each cycle and registered to the wr_* outputs on the next edge (1-cycle latency):
  - Priority 1: alu_we && alu_addr!=0 writes the ALU result.
  - Priority 2: otherwise, if the buffer head is live and its address is nonzero, write the head and pop it.
  - Priority 3: otherwise wr_en=0; wr_addr and wr_data hold their previous values.
- Dead or zero-address head:
  - A head that is not live, or live with address 0, is popped without a write.
  - This pop happens in any cycle, including cycles when the ALU takes the port.
- Register 0: writes to address 0 are never issued from either source.
- Bypass: a load arriving while the buffer is empty and the ALU is idle still passes through the buffer. Load-to-wr_en latency is 2 cycles: enqueue edge, then output edge.
- Ordering and squash (program order: buffered loads are older than the current ALU result):
  - An ALU write to register r clears the live bit of every buffered entry with address r, in the same cycle.
  - A load accepted in the same cycle as an ALU write to the same r is younger: it is enqueued live.
- Buffer:
  - Circular, with read/write pointers of log2(DEPTH) bits that wrap naturally.
  - A count of 0..DEPTH distinguishes full from empty.
  - Push and pop in the same cycle while full is impossible because ld_ready=0; while empty, the push is not visible to the same-cycle pop.
- pending_mask: OR over live entries of one-hot(addr), combinational from state. A squash removes the bit on the edge that applies it.

Decomposition:
- Shared package:
  - Constants ADW and DW.
  - Buffer entry struct {live, addr, data}.
  - Function onehot(addr).
- One sub-module, regwb_load_fifo:
  - DEPTH-entry buffer with push/pop, full/empty, and per-entry squash by address compare.
- The top level holds the selection mux, the output registers and the mask reduction.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> wr_en=0, wr_addr=0, wr_data=0, pending_mask=0; after release ld_ready=1.
- ALU only: alu_we=1, addr=5, data=0xDEADBEEF at cycle t -> wr_en=1, wr_addr=5, wr_data=0xDEADBEEF at t+1. Same stimulus with addr=0 -> wr_en=0.
- Load only: load addr=9, data=0x1234 accepted at t -> pending_mask[9]=1 at t+1; wr_en with addr 9, data 0x1234 at t+2; pending_mask[9]=0 at t+2.
- Collision and full:
  - Stimulus: ALU writes continuously to addr 3 for 6 cycles while 5 loads arrive to addrs 10..14.
  - ld_ready must drop after 4 entries and the 5th load must stall.
  - Each load must be written in order after the ALU stops; no load is lost.
- Squash: load to addr 7 buffered behind ALU traffic, then ALU writes addr 7 -> the load is never written; pending_mask[7] clears; the head pops silently.
- Same-cycle same address: ALU write to r=4 and load accept to r=4 in one cycle -> ALU write first, then the load data for r=4 two cycles later.
